ysyx_23060184_lsu_axi: RTL and testbench

//  Parametrised AXI4 load/store unit between EXU and WBU. Accepts one memory op per upstream handshake
//  and owns the single-beat AXI4 master on the LSU side of the arbiter (req/grant).

---
 rtl/ysyx_23060184_lsu_axi.sv | 226 ++++++++++++++++++++++
 tb/tb_ysyx_23060184_lsu_axi.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_lsu_axi.sv
// Load/store unit: one EXU op at a time, single-beat AXI4 master behind a req/grant arbiter.
// Sub-word stores are lane-shifted with strobes; sub-word loads are extracted and extended.
module ysyx_23060184_lsu_axi #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int LSU_ID  = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  e_valid,
  output logic                  e_ready,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [2:0]            funct3,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata_in,
  output logic                  m_valid,
  input  logic                  w_ready,
  output logic [DATA_W-1:0]     rdata_out,
  output logic [1:0]            err,
  output logic                  req,
  input  logic                  grant,
  output logic [ADDR_W-1:0]     araddr,
  output logic [ID_W-1:0]       arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [ID_W-1:0]       rid,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [ID_W-1:0]       awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic [ID_W-1:0]       bid,
  input  logic                  bvalid,
  output logic                  bready
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, REQ, AR, R, WR, B, RESP} state_t;

  typedef struct packed {
    logic              ld;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } op_t;

  state_t      state;
  op_t         op;
  logic [31:0] tmo_cnt;

  logic [LANE_W-1:0] lane;
  logic [1:0]        size;
  logic              misaligned, tmo, r_hit, b_hit, r_err, b_err, aw_ok, w_ok;
  logic [7:0]        amt;
  logic [DATA_W-1:0] rd_sh, rd_up, ld_ext;
  logic signed [DATA_W-1:0] ld_sx;
  logic [STRB_W-1:0] strb_base;

  assign lane = op.addr[LANE_W-1:0];
  assign size = op.f3[1:0];

  // size 3 overflows the 3-bit shift to 0, so the mask becomes 3'b111
  assign misaligned = |(addr[2:0] & ((3'd1 << funct3[1:0]) - 3'd1));

  assign tmo   = (TIMEOUT > 0) && (tmo_cnt == 32'(TIMEOUT - 1));
  assign r_hit = rvalid && (rid == ID_W'(LSU_ID));
  assign b_hit = bvalid && (bid == ID_W'(LSU_ID));
  // a single-beat read that arrives without rlast is a protocol error
  assign r_err = (rresp inside {2'b10, 2'b11}) || !rlast;
  assign b_err = bresp inside {2'b10, 2'b11};
  assign aw_ok = !awvalid || awready;
  assign w_ok  = !wvalid || wready;

  // Move the addressed lane down, then push the field to the top and shift back to extend.
  always_comb begin
    case (size)
      2'd0:    amt = 8'(DATA_W - 8);
      2'd1:    amt = 8'(DATA_W - 16);
      2'd2:    amt = 8'(DATA_W - 32);
      default: amt = '0;
    endcase
    rd_sh  = rdata >> {lane, 3'b000};
    rd_up  = rd_sh << amt;
    ld_sx  = $signed(rd_up) >>> amt;
    ld_ext = op.f3[2] ? (rd_up >> amt) : ld_sx;
  end

  assign strb_base = STRB_W'((16'h1 << (5'd1 << size)) - 16'h1);
  assign wstrb     = strb_base << lane;
  assign wdata     = op.wdata << {lane, 3'b000};

  assign araddr  = op.addr;
  assign awaddr  = op.addr;
  assign arid    = ID_W'(LSU_ID);
  assign awid    = ID_W'(LSU_ID);
  assign arlen   = '0;
  assign awlen   = '0;
  assign arsize  = {1'b0, size};
  assign awsize  = {1'b0, size};
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op        <= '0;
      tmo_cnt   <= '0;
      e_ready   <= 1'b1;
      m_valid   <= 1'b0;
      rdata_out <= '0;
      err       <= 2'b00;
      req       <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
      if (tmo && (state inside {AR, R, WR, B})) begin
        // abandon the bus; any late response finds rready/bready low
        arvalid   <= 1'b0;
        rready    <= 1'b0;
        awvalid   <= 1'b0;
        wvalid    <= 1'b0;
        bready    <= 1'b0;
        req       <= 1'b0;
        err       <= 2'b11;
        rdata_out <= '0;
        m_valid   <= 1'b1;
        state     <= RESP;
      end else begin
        case (state)
          IDLE: if (e_valid) begin
            e_ready <= 1'b0;
            op      <= '{ld: mem_rd, f3: funct3, addr: addr, wdata: wdata_in};
            err     <= 2'b00;
            if (!mem_rd && !mem_wr) begin
              rdata_out <= DATA_W'(addr);
              m_valid   <= 1'b1;
              state     <= RESP;
            end else if (misaligned) begin
              rdata_out <= '0;
              err       <= 2'b01;
              m_valid   <= 1'b1;
              state     <= RESP;
            end else begin
              req   <= 1'b1;
              state <= REQ;
            end
          end
          REQ: if (grant) begin
            tmo_cnt <= '0;
            if (op.ld) begin
              arvalid <= 1'b1;
              state   <= AR;
            end else begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WR;
            end
          end
          AR: if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            tmo_cnt <= '0;
            state   <= R;
          end
          R: if (r_hit) begin
            rready    <= 1'b0;
            req       <= 1'b0;
            rdata_out <= ld_ext;
            err       <= r_err ? 2'b10 : 2'b00;
            m_valid   <= 1'b1;
            state     <= RESP;
          end
          WR: begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
            if (aw_ok && w_ok) begin
              bready  <= 1'b1;
              tmo_cnt <= '0;
              state   <= B;
            end
          end
          B: if (b_hit) begin
            bready    <= 1'b0;
            req       <= 1'b0;
            rdata_out <= '0;
            err       <= b_err ? 2'b10 : 2'b00;
            m_valid   <= 1'b1;
            state     <= RESP;
          end
          RESP: if (w_ready) begin
            m_valid <= 1'b0;
            e_ready <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_lsu_axi.sv
// Bench for the LSU: negedge-driven AXI slave with per-channel ready delays,
// and a response scoreboard filled at issue time and drained on m_valid&w_ready.
module tb_ysyx_23060184_lsu_axi;
  localparam int DW = 32, AW = 32, IW = 4, LID = 1, TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          e_valid, e_ready, mem_rd, mem_wr;
  logic [2:0]    funct3;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata_in;
  logic          m_valid, w_ready;
  logic [DW-1:0] rdata_out;
  logic [1:0]    err;
  logic          req, grant;
  logic [AW-1:0] araddr, awaddr;
  logic [IW-1:0] arid, rid, awid, bid;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst, rresp, bresp;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0] rdata, wdata;
  logic [DW/8-1:0] wstrb;

  ysyx_23060184_lsu_axi #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .LSU_ID(LID), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_ready(e_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .funct3(funct3), .addr(addr), .wdata_in(wdata_in), .m_valid(m_valid), .w_ready(w_ready),
    .rdata_out(rdata_out), .err(err), .req(req), .grant(grant),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid),
    .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bid(bid), .bvalid(bvalid),
    .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] err; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  // slave knobs and observations
  int ar_dly = 0, aw_dly = 0, w_dly = 0;
  logic r_en = 1'b1;
  logic [31:0] r_data = '0;
  logic [1:0] r_resp_v = 2'b00, b_resp_v = 2'b00;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, ar_cycles = 0, aw_cycles = 0, b_cycles = 0;
  logic [31:0] obs_wdata = '0;
  logic [3:0]  obs_wstrb = '0;
  logic [2:0]  obs_arsize = '0;

  initial begin
    grant = 0; arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = '0; rresp = 2'b00; rlast = 1'b1; rid = IW'(LID); bresp = 2'b00; bid = IW'(LID);
    forever begin
      @(negedge clk);
      grant = req;
      if (arvalid) begin
        arready = (ar_cnt >= ar_dly); ar_cnt++; ar_cycles++; obs_arsize = arsize;
      end else begin arready = 0; ar_cnt = 0; end
      rvalid = rready && r_en; rdata = r_data; rresp = r_resp_v;
      if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; aw_cycles++; end
      else begin awready = 0; aw_cnt = 0; end
      if (wvalid) begin
        wready = (w_cnt >= w_dly); w_cnt++;
        if (wready) begin obs_wdata = wdata; obs_wstrb = wstrb; end
      end else begin wready = 0; w_cnt = 0; end
      bvalid = bready; bresp = b_resp_v;
      if (bready) b_cycles++;
    end
  end

  // scoreboard drain on each result handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1 && w_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: rdata_out=%h err=%b, required no response", rdata_out, err);
        end else begin
          e = sb.pop_front();
          if (rdata_out !== e.data || err !== e.err) begin
            errors++;
            $display("FAIL sb_resp: rdata_out=%h err=%b, required %h/%b", rdata_out, err, e.data, e.err);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] xd, input logic [1:0] xe);
    exp_t e;
    bit ok;
    e.data = xd; e.err = xe; sb.push_back(e);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata_in = wd; e_valid = 1'b1; ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin @(negedge clk); ok = (e_ready === 1'b1); end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: e_ready=%b, required 1 within 64 cycles", e_ready);
      e_valid = 1'b0;
    end else begin
      @(posedge clk); #1; e_valid = 1'b0;
    end
  endtask

  task automatic wait_mvalid(output int lat);
    lat = 0;
    while (lat < 64) begin
      @(negedge clk); lat++;
      if (m_valid === 1'b1) break;
    end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: m_valid=%b, required 1 within 64 cycles", m_valid);
    end
  endtask

  task automatic finish_op();
    int lat;
    wait_mvalid(lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; e_valid = 0; mem_rd = 0; mem_wr = 0; funct3 = 0; addr = 0; wdata_in = 0; w_ready = 1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if ({e_ready, m_valid, req, arvalid, rready, awvalid, wvalid, bready} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 10000000",
               {e_ready, m_valid, req, arvalid, rready, awvalid, wvalid, bready});
    end
    checks++;
    if (err !== 2'b00 || rdata_out !== 32'h0) begin
      errors++; $display("FAIL reset_data: err=%b rdata_out=%h, required 00/0", err, rdata_out);
    end
    checks++;
    if ({arlen, awlen, arburst, awburst, wlast, arid, awid} !== {8'h0, 8'h0, 2'b01, 2'b01, 1'b1, 4'h1, 4'h1}) begin
      errors++;
      $display("FAIL const_outputs: len=%h/%h burst=%b/%b wlast=%b id=%h/%h, required 0/0 01/01 1 1/1",
               arlen, awlen, arburst, awburst, wlast, arid, awid);
    end
  endtask

  task automatic test_load_word();
    int lat;
    r_data = 32'hDEAD_BEEF;
    issue(1, 0, 3'b010, 32'h8000_0004, 0, 32'hDEAD_BEEF, 2'b00);
    wait_mvalid(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL load_latency: %0d cycles, required 4", lat); end
    @(posedge clk); #1;
    checks++;
    if (obs_arsize !== 3'd2) begin errors++; $display("FAIL lw_arsize: %0d, required 2", obs_arsize); end
  endtask

  task automatic test_load_sub();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] as  [4] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002};
    logic [31:0] rds [4] = '{32'h8012_3456, 32'h8012_3456, 32'hABCD_1234, 32'hABCD_1234};
    logic [31:0] xs  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_ABCD, 32'h0000_ABCD};
    for (int i = 0; i < 4; i++) begin
      r_data = rds[i];
      issue(1, 0, f3s[i], as[i], 0, xs[i], 2'b00);
      finish_op();
    end
  endtask

  task automatic test_store();
    int          awd [4] = '{0, 3, 0, 0};
    int          wdl [4] = '{3, 0, 0, 0};
    logic [2:0]  f3s [4] = '{3'b001, 3'b001, 3'b000, 3'b010};
    logic [31:0] as  [4] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0001, 32'h8000_0008};
    logic [31:0] wds [4] = '{32'h1234, 32'h1234, 32'hAB, 32'hCAFE_F00D};
    logic [31:0] xw  [4] = '{32'h1234_0000, 32'h1234_0000, 32'h0000_AB00, 32'hCAFE_F00D};
    logic [3:0]  xs  [4] = '{4'b1100, 4'b1100, 4'b0010, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      aw_dly = awd[i]; w_dly = wdl[i]; b_cycles = 0; obs_wdata = '0; obs_wstrb = '0;
      issue(0, 1, f3s[i], as[i], wds[i], 32'h0, 2'b00);
      finish_op();
      checks++;
      if (obs_wdata !== xw[i] || obs_wstrb !== xs[i]) begin
        errors++;
        $display("FAIL store_lane[%0d]: wdata=%h wstrb=%b, required %h/%b", i, obs_wdata, obs_wstrb, xw[i], xs[i]);
      end
      checks++;
      if (b_cycles != 1) begin
        errors++; $display("FAIL store_bwait[%0d]: %0d B cycles, required 1", i, b_cycles);
      end
    end
    aw_dly = 0; w_dly = 0;
  endtask

  task automatic test_errors();
    ar_cycles = 0;
    issue(1, 0, 3'b010, 32'h8000_0001, 0, 32'h0, 2'b01);
    finish_op();
    checks++;
    if (ar_cycles != 0) begin errors++; $display("FAIL misaligned_lw_bus: %0d arvalid cycles, required 0", ar_cycles); end
    aw_cycles = 0;
    issue(0, 1, 3'b001, 32'h8000_0003, 32'h77, 32'h0, 2'b01);
    finish_op();
    checks++;
    if (aw_cycles != 0) begin errors++; $display("FAIL misaligned_sh_bus: %0d awvalid cycles, required 0", aw_cycles); end
    b_resp_v = 2'b10;
    issue(0, 1, 3'b010, 32'h8000_0008, 32'h55, 32'h0, 2'b10);
    finish_op();
    b_resp_v = 2'b00;
    r_resp_v = 2'b11; r_data = 32'h1111_1111;
    issue(1, 0, 3'b010, 32'h8000_0010, 0, 32'h1111_1111, 2'b10);
    finish_op();
    r_resp_v = 2'b00;
  endtask

  task automatic test_timeout();
    int lat;
    ar_dly = 1000; ar_cycles = 0;
    issue(1, 0, 3'b010, 32'h8000_0020, 0, 32'h0, 2'b11);
    wait_mvalid(lat);
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL timeout_req: req=%b, required 0", req); end
    @(posedge clk); #1;
    checks++;
    if (ar_cycles != 16) begin errors++; $display("FAIL timeout_ar_cycles: %0d, required 16", ar_cycles); end
    ar_dly = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] as [3] = '{32'h1234_5678, 32'h0000_0003, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 3'b010, as[i], 0, as[i], 2'b00);
      finish_op();
      checks++;
      if (e_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: e_ready=%b one cycle after handshake, required 1", i, e_ready);
      end
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    bit ok;
    r_en = 1'b0; ok = 0;
    issue(1, 0, 3'b010, 32'h8000_0040, 0, 32'h0, 2'b00);
    for (int i = 0; i < 32 && !ok; i++) begin @(negedge clk); ok = (rready === 1'b1); end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach_r: rready=%b, required 1", rready); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    sb.delete();
    checks++;
    if ({e_ready, m_valid, req, arvalid, rready, awvalid, wvalid, bready} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL abort_ctrl: got %b, required 10000000",
               {e_ready, m_valid, req, arvalid, rready, awvalid, wvalid, bready});
    end
    checks++;
    if (err !== 2'b00 || rdata_out !== 32'h0) begin
      errors++; $display("FAIL abort_data: err=%b rdata_out=%h, required 00/0", err, rdata_out);
    end
    r_en = 1'b1; w_ready = 1'b0;
    issue(0, 0, 3'b010, 32'hCAFE_0000, 0, 32'hCAFE_0000, 2'b00);
    wait_mvalid(lat);
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || rdata_out !== 32'hCAFE_0000) begin
        errors++; $display("FAIL stall_hold: m_valid=%b rdata_out=%h, required 1/cafe0000", m_valid, rdata_out);
      end
    end
    @(posedge clk); #1; w_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (e_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: e_ready=%b m_valid=%b, required 1/0", e_ready, m_valid);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_sub();
    test_store();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d responses outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
